// File: rtl/div4_seq.sv
// Sequential 4-bit unsigned restoring divider: one trial subtraction per cycle, MSB first.
// Optional DIV4_SEQ_DBZ_EN adds a dbz port and a short-circuit path for a zero divisor.
module div4_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [3:0] q,
    output logic [3:0] r
`ifdef DIV4_SEQ_DBZ_EN
    ,
    output logic       dbz
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] d_q, d_d;
    logic [3:0] b_q, b_d;
    logic [3:0] q_q, q_d;
    logic [3:0] r_q, r_d;
    logic [1:0] cnt_q, cnt_d;
    logic       dbz_q, dbz_d;

    logic [1:0] idx;
    logic       bit_in;
    logic       borrow;
    logic [3:0] rem_trial;
    logic       zdiv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            d_q     <= '0;
            b_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            b_q     <= b_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    // Upper bit of the 5-bit trial is zero whenever there is no borrow, so only 4 bits are kept.
    always_comb begin
        idx       = 2'd3 - cnt_q;
        bit_in    = d_q[idx];
        borrow    = ({r_q, bit_in} < {1'b0, b_q});
        rem_trial = 4'({r_q, bit_in} - {1'b0, b_q});
`ifdef DIV4_SEQ_DBZ_EN
        zdiv      = (b_q == 4'd0);
`else
        zdiv      = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        b_d     = b_q;
        q_d     = q_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    d_d     = a;
                    b_d     = b;
                    q_d     = '0;
                    r_d     = '0;
                    cnt_d   = '0;
                    dbz_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (zdiv) begin
                    q_d     = '1;
                    r_d     = d_q;
                    dbz_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    if (!borrow) begin
                        q_d[idx] = 1'b1;
                        r_d      = rem_trial;
                    end else begin
                        q_d[idx] = 1'b0;
                        r_d      = {r_q[2:0], bit_in};
                    end
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN) && !zdiv;
    assign done = (state_q == DONE);
    assign q    = q_q;
    assign r    = r_q;
`ifdef DIV4_SEQ_DBZ_EN
    assign dbz  = dbz_q;
`else
    logic unused_dbz;
    assign unused_dbz = dbz_q;
`endif

endmodule

// File: tb/tb_div4_seq.sv
// Scoreboard bench for div4_seq: driver pushes expected results, a negedge monitor checks each done.
module tb_div4_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a, b;
    logic       busy, done;
    logic [3:0] q, r;
`ifdef DIV4_SEQ_DBZ_EN
    logic       dbz;
`endif

    div4_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r)
`ifdef DIV4_SEQ_DBZ_EN
        ,
        .dbz   (dbz)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        int         acc;
        int         lat;
        int         busyc;
        logic       dz;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected none (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    chk("q", int'(q), int'(e.q));
                    chk("r", int'(r), int'(e.r));
                    chk("latency", cyc - e.acc, e.lat);
                    chk("busy_cycles", busy_cnt, e.busyc);
`ifdef DIV4_SEQ_DBZ_EN
                    chk("dbz", int'(dbz), int'(e.dz));
`endif
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic issue(input logic [3:0] av, input logic [3:0] bv, input logic [3:0] qv,
                         input logic [3:0] rv, input int lat, input int busyc, input logic dz);
        exp_t e;
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = ~av;
        b     = ~bv;
        e.q = qv; e.r = rv; e.acc = cyc; e.lat = lat; e.busyc = busyc; e.dz = dz;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    typedef struct { logic [3:0] a, b, q, r; } vec_t;
    vec_t vecs[4] = '{
        '{4'd13, 4'd4, 4'd3,  4'd1},
        '{4'd15, 4'd1, 4'd15, 4'd0},
        '{4'd3,  4'd7, 4'd0,  4'd3},
        '{4'd0,  4'd9, 4'd0,  4'd0}
    };

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_q", int'(q), 0);
        chk("rst_r", int'(r), 0);
`ifdef DIV4_SEQ_DBZ_EN
        chk("rst_dbz", int'(dbz), 0);
`endif
        rst = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 4, 4, 1'b0);
            wait_idle();
        end

        // start held during RUN must be dropped without queuing a second result
        issue(4'd14, 4'd3, 4'd4, 4'd2, 4, 4, 1'b0);
        start = 1'b1; a = 4'd9; b = 4'd2;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (8) @(negedge clk);

`ifdef DIV4_SEQ_DBZ_EN
        issue(4'd6, 4'd0, 4'd15, 4'd6, 1, 0, 1'b1);
`else
        issue(4'd6, 4'd0, 4'd15, 4'd6, 4, 4, 1'b0);
`endif
        wait_idle();

        issue(4'd13, 4'd4, 4'd3, 4'd1, 4, 4, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_q", int'(q), 0);
        chk("abort_r", int'(r), 0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        issue(4'd11, 4'd3, 4'd3, 4'd2, 4, 4, 1'b0);
        wait_idle();

        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 1; bi < 16; bi++) begin
                issue(4'(ai), 4'(bi), 4'(ai / bi), 4'(ai % bi), 4, 4, 1'b0);
                wait_idle();
            end
        end

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
